uart_tx_packet_serializer: RTL and testbench

- Parametrised UART transmit serializer for the UART MVM system.
- Takes one multi-word result bus through a valid/ready handshake and sends it as N_WORDS consecutive UART frames, word 0 first.
- Each frame is a start bit, data LSB-first, optional even/odd parity, then stop/padding bits up to a fixed frame length.
- Successor to the fixed-format TX path. Adds parity, a configurable word count and backpressure via s_ready.

---
 rtl/uart_tx_packet_serializer.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_packet_serializer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_packet_serializer.sv
// UART transmit serializer: accepts an N_WORDS-wide payload over valid/ready and
// emits it as back-to-back UART frames (start, data LSB-first, optional parity, stop/padding).
module uart_tx_packet_serializer #(
    parameter int CLOCKS_PER_PULSE = 33,
    parameter int BITS_PER_WORD    = 8,
    parameter int N_WORDS          = 2,
    parameter int PACKET_SIZE      = 13,
    parameter int PARITY_EN        = 0,
    parameter int PARITY_ODD       = 0
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [N_WORDS*BITS_PER_WORD-1:0]   s_data,
    input  logic                               s_valid,
    output logic                               s_ready,
    output logic                               tx,
    output logic                               busy,
    output logic                               frame_done
);

    localparam int DW = N_WORDS * BITS_PER_WORD;
    localparam int CW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int BW = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
    localparam int WW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    localparam logic [CW-1:0] CYC_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(PACKET_SIZE - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(N_WORDS - 1);

    generate
        if (PACKET_SIZE < BITS_PER_WORD + 2 + PARITY_EN || CLOCKS_PER_PULSE < 2) begin : g_bad_params
            $error("uart_tx_packet_serializer: PACKET_SIZE too small or CLOCKS_PER_PULSE < 2");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cyc_q, cyc_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [WW-1:0]      word_q, word_d;
    logic [DW-1:0]      data_q, data_d;
    logic               tx_q, tx_d;
    logic               done_q, done_d;

    logic                     accept;
    logic                     bit_end;
    logic                     frame_end;
    logic                     last_word;
    logic [BW-1:0]            bit_nxt;
    logic [BITS_PER_WORD-1:0] cur_word;
    logic [BITS_PER_WORD-1:0] cur_shift;
    logic                     nxt_bit_val;
    int                       nb;

    assign accept    = s_valid && (state_q == IDLE);
    assign bit_end   = (state_q == SEND) && (cyc_q == CYC_LAST);
    assign frame_end = bit_end && (bit_q == BIT_LAST);
    assign last_word = (word_q == WORD_LAST);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (s_valid) state_d = SEND;
            SEND: if (frame_end && last_word) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        s_ready = (state_q == IDLE);
        busy    = (state_q == SEND);
    end

    assign tx         = tx_q;
    assign frame_done = done_q;

    // Line value of the bit that starts once the current bit finishes (same word)
    always_comb begin
        cur_word    = BITS_PER_WORD'(data_q >> (int'(word_q) * BITS_PER_WORD));
        bit_nxt     = bit_q + 1'b1;
        nb          = int'(bit_nxt);
        cur_shift   = '0;
        nxt_bit_val = 1'b1;
        if (nb == 0) begin
            nxt_bit_val = 1'b0;
        end else if (nb <= BITS_PER_WORD) begin
            cur_shift   = cur_word >> (nb - 1);
            nxt_bit_val = cur_shift[0];
        end else if (PARITY_EN != 0 && nb == BITS_PER_WORD + 1) begin
            nxt_bit_val = (^cur_word) ^ (PARITY_ODD != 0);
        end
    end

    always_comb begin
        cyc_d  = cyc_q;
        bit_d  = bit_q;
        word_d = word_q;
        data_d = data_q;
        tx_d   = tx_q;
        done_d = 1'b0;
        if (accept) begin
            data_d = s_data;
            cyc_d  = '0;
            bit_d  = '0;
            word_d = '0;
            tx_d   = 1'b0;
        end else if (state_q == SEND) begin
            if (bit_end) begin
                cyc_d = '0;
                if (bit_q == BIT_LAST) begin
                    bit_d = '0;
                    if (last_word) begin
                        word_d = '0;
                        tx_d   = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        word_d = word_q + 1'b1;
                        tx_d   = 1'b0;
                    end
                end else begin
                    bit_d = bit_nxt;
                    tx_d  = nxt_bit_val;
                end
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_q  <= '0;
            bit_q  <= '0;
            word_q <= '0;
            data_q <= '0;
            tx_q   <= 1'b1;
            done_q <= 1'b0;
        end else begin
            cyc_q  <= cyc_d;
            bit_q  <= bit_d;
            word_q <= word_d;
            data_q <= data_d;
            tx_q   <= tx_d;
            done_q <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_packet_serializer.sv
// Directed bench for uart_tx_packet_serializer: default-format instance plus even- and
// odd-parity instances, sampled at bit centres on the falling clock edge.
module tb_uart_tx_packet_serializer;

    localparam int CPP = 33;
    localparam int PS  = 13;
    localparam int TXN = 2 * PS * CPP;   // 858 cycles per transaction

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] s_data0 = 16'h0;
    logic        s_valid0 = 1'b0;
    logic [15:0] s_data_p = 16'h0;
    logic        s_valid_p = 1'b0;

    logic s_ready0, tx0, busy0, frame_done0;
    logic s_ready_pe, tx_pe, busy_pe, frame_done_pe;
    logic s_ready_po, tx_po, busy_po, frame_done_po;

    int checks = 0;
    int errors = 0;

    logic [63:0] bits0, bits_pe, bits_po;
    int  rdy_hi0, done_first0, done_cnt0, done_first_pe;
    logic first_tx0, last_tx0, last_rdy0;

    always #5 clk = ~clk;

    uart_tx_packet_serializer dut0 (
        .clk(clk), .rstn(rstn), .s_data(s_data0), .s_valid(s_valid0),
        .s_ready(s_ready0), .tx(tx0), .busy(busy0), .frame_done(frame_done0)
    );

    uart_tx_packet_serializer #(.PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
        .clk(clk), .rstn(rstn), .s_data(s_data_p), .s_valid(s_valid_p),
        .s_ready(s_ready_pe), .tx(tx_pe), .busy(busy_pe), .frame_done(frame_done_pe)
    );

    uart_tx_packet_serializer #(.PARITY_EN(1), .PARITY_ODD(1)) dut_po (
        .clk(clk), .rstn(rstn), .s_data(s_data_p), .s_valid(s_valid_p),
        .s_ready(s_ready_po), .tx(tx_po), .busy(busy_po), .frame_done(frame_done_po)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] frm(input logic [63:0] b, input int f);
        return b[f*PS +: PS];
    endfunction

    // Runs n_negs falling edges starting right after an acceptance edge, capturing
    // bit-centre samples and handshake observations.
    task automatic run_window(input int n_negs, input bit drop_valid, input int pulse_at);
        bits0 = '0; bits_pe = '0; bits_po = '0;
        rdy_hi0 = 0; done_first0 = -1; done_cnt0 = 0; done_first_pe = -1;
        for (int n = 0; n < n_negs; n++) begin
            @(negedge clk);
            if (n == 0 && drop_valid) begin
                s_valid0  = 1'b0;
                s_valid_p = 1'b0;
            end
            if (n == pulse_at) begin
                s_data0  = 16'hAAAA;
                s_valid0 = 1'b1;
            end
            if (pulse_at >= 0 && n == pulse_at + 1) s_valid0 = 1'b0;
            if (n % CPP == CPP / 2 && n / CPP < 64) begin
                bits0[n/CPP]   = tx0;
                bits_pe[n/CPP] = tx_pe;
                bits_po[n/CPP] = tx_po;
            end
            if (n < n_negs - 1 && s_ready0) rdy_hi0++;
            if (frame_done0) begin
                done_cnt0++;
                if (done_first0 < 0) done_first0 = n;
            end
            if (frame_done_pe && done_first_pe < 0) done_first_pe = n;
            if (n == 0) first_tx0 = tx0;
            if (n == n_negs - 1) begin
                last_tx0  = tx0;
                last_rdy0 = s_ready0;
            end
        end
    endtask

    initial begin
        // 1. Reset held with s_valid asserted
        s_valid0 = 1'b1;
        s_valid_p = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx0, 1'b1);
        chk("rst_ready", s_ready0, 1'b1);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", frame_done0, 1'b0);
        chk("rst_tx_pe", tx_pe, 1'b1);
        s_valid0 = 1'b0;
        s_valid_p = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", busy0, 1'b0);

        // 2. Default format, A53C, single-cycle valid
        s_data0 = 16'hA53C;
        s_valid0 = 1'b1;
        @(posedge clk);
        #1 s_valid0 = 1'b0;
        run_window(TXN + 1, 1'b0, -1);
        chk("t2_frame0", frm(bits0, 0), {4'hF, 8'h3C, 1'b0});
        chk("t2_frame1", frm(bits0, 1), {4'hF, 8'hA5, 1'b0});
        chk("t2_done_at", done_first0, TXN);
        chk("t2_done_cnt", done_cnt0, 1);
        chk("t2_ready_low", rdy_hi0, 0);
        chk("t2_end_ready", last_rdy0, 1'b1);
        @(negedge clk);
        chk("t2_done_pulse", frame_done0, 1'b0);
        chk("t2_idle_tx", tx0, 1'b1);

        // 3. Parity instances: 0107 then A53C
        s_data_p = 16'h0107;
        s_valid_p = 1'b1;
        @(posedge clk);
        run_window(TXN + 1, 1'b1, -1);
        chk("t3_even_f0", frm(bits_pe, 0), {3'b111, 1'b1, 8'h07, 1'b0});
        chk("t3_even_f1", frm(bits_pe, 1), {3'b111, 1'b1, 8'h01, 1'b0});
        chk("t3_odd_f0", frm(bits_po, 0), {3'b111, 1'b0, 8'h07, 1'b0});
        chk("t3_odd_f1", frm(bits_po, 1), {3'b111, 1'b0, 8'h01, 1'b0});
        chk("t3_done_at", done_first_pe, TXN);
        @(negedge clk);
        s_data_p = 16'hA53C;
        s_valid_p = 1'b1;
        @(posedge clk);
        run_window(TXN + 1, 1'b1, -1);
        chk("t3_even_a5_f0", frm(bits_pe, 0), {3'b111, 1'b0, 8'h3C, 1'b0});
        chk("t3_even_a5_f1", frm(bits_pe, 1), {3'b111, 1'b0, 8'hA5, 1'b0});
        chk("t3_odd_a5_f0", frm(bits_po, 0), {3'b111, 1'b1, 8'h3C, 1'b0});

        // 4. Back-to-back with s_valid held high
        @(negedge clk);
        s_data0 = 16'h1234;
        s_valid0 = 1'b1;
        @(posedge clk);
        #1 s_data0 = 16'hFFFF;
        run_window(TXN + 1, 1'b0, -1);
        chk("t4_frame0", frm(bits0, 0), {4'hF, 8'h34, 1'b0});
        chk("t4_frame1", frm(bits0, 1), {4'hF, 8'h12, 1'b0});
        chk("t4_done_at", done_first0, TXN);
        chk("t4_gap_tx", last_tx0, 1'b1);
        run_window(TXN + 1, 1'b1, -1);
        chk("t4_restart_tx", first_tx0, 1'b0);
        chk("t4_frame2", frm(bits0, 0), {4'hF, 8'hFF, 1'b0});
        chk("t4_frame3", frm(bits0, 1), {4'hF, 8'hFF, 1'b0});
        chk("t4_done2_at", done_first0, TXN);

        // 5. Payload change and valid pulse while busy are ignored
        @(negedge clk);
        s_data0 = 16'h00FF;
        s_valid0 = 1'b1;
        @(posedge clk);
        run_window(TXN + 1, 1'b1, 300);
        chk("t5_frame0", frm(bits0, 0), {4'hF, 8'hFF, 1'b0});
        chk("t5_frame1", frm(bits0, 1), {4'hF, 8'h00, 1'b0});
        chk("t5_ready_low", rdy_hi0, 0);
        chk("t5_done_at", done_first0, TXN);
        repeat (3) @(negedge clk);
        chk("t5_no_second_busy", busy0, 1'b0);
        chk("t5_no_second_tx", tx0, 1'b1);

        // 6. Asynchronous reset during data bit 3 of word 1
        s_data0 = 16'h00F0;
        s_valid0 = 1'b1;
        @(posedge clk);
        #1 s_valid0 = 1'b0;
        repeat ((PS + 4) * CPP + CPP / 2 + 1) @(negedge clk);
        chk("t6_pre_tx", tx0, 1'b0);
        chk("t6_pre_busy", busy0, 1'b1);
        #1 rstn = 1'b0;
        #1;
        chk("t6_async_tx", tx0, 1'b1);
        chk("t6_async_ready", s_ready0, 1'b1);
        chk("t6_async_busy", busy0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        s_data0 = 16'h5A5A;
        s_valid0 = 1'b1;
        @(posedge clk);
        run_window(TXN + 1, 1'b1, -1);
        chk("t6_frame0", frm(bits0, 0), {4'hF, 8'h5A, 1'b0});
        chk("t6_frame1", frm(bits0, 1), {4'hF, 8'h5A, 1'b0});
        chk("t6_done_at", done_first0, TXN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
